// File: rtl/timer_sched.sv
// Round-robin scheduler that shares one APB timer between NUM_CH one-shot delay requesters.
// Each granted request programs the timer, waits for the compare irq, stops the timer and reports completion.
module timer_sched #(
    parameter int         NUM_CH         = 4,
    parameter int         APB_ADDR_WIDTH = 12,
    parameter logic [2:0] PRESCALER      = 3'd0
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [NUM_CH-1:0]           req_i,
    input  logic [NUM_CH*32-1:0]        period_i,
    output logic [NUM_CH-1:0]           ack_o,
    output logic [NUM_CH-1:0]           done_o,
    output logic [NUM_CH-1:0]           aborted_o,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch_o,
    output logic [APB_ADDR_WIDTH-1:0]   PADDR,
    output logic [31:0]                 PWDATA,
    output logic                        PWRITE,
    output logic                        PSEL,
    output logic                        PENABLE,
    input  logic                        PREADY,
    input  logic                        PSLVERR,
    input  logic [31:0]                 PRDATA,
    input  logic                        timer_cmp_irq_i
);
    localparam int CW = $clog2(NUM_CH);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL = APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CMP  = APB_ADDR_WIDTH'(8);
    localparam logic [31:0] CTRL_ON = {26'b0, PRESCALER, 2'b0, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        WR_CTRL_OFF,
        WR_CMP,
        WR_CTRL_ON,
        WAIT_IRQ,
        WR_STOP,
        FINISH
    } state_t;

    state_t        state, state_next;
    logic          access, access_next;
    logic          abort_flag, abort_flag_next;
    logic [CW-1:0] ch, rr, rr_next;
    logic [31:0]   period;
    logic          grant_valid;
    logic [CW-1:0] grant_idx;
    logic [31:0]   grant_period;
    logic          is_write;
    logic          unused_prdata;

    assign unused_prdata = ^PRDATA;
    assign is_write = (state == WR_CTRL_OFF) || (state == WR_CMP) ||
                      (state == WR_CTRL_ON)  || (state == WR_STOP);

    // First pass covers channels at or after rr, second pass the wrap-around below rr.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_period = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_valid && req_i[k] && (k >= int'(rr))) begin
                grant_valid  = 1'b1;
                grant_idx    = CW'(k);
                grant_period = period_i[k*32 +: 32];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_valid && req_i[k]) begin
                grant_valid  = 1'b1;
                grant_idx    = CW'(k);
                grant_period = period_i[k*32 +: 32];
            end
        end
    end

    assign rr_next = (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + CW'(1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            access     <= 1'b0;
            abort_flag <= 1'b0;
        end else begin
            state      <= state_next;
            access     <= access_next;
            abort_flag <= abort_flag_next;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ch     <= '0;
            rr     <= '0;
            period <= '0;
        end else if (state == IDLE && grant_valid) begin
            ch     <= grant_idx;
            rr     <= rr_next;
            period <= grant_period;
        end
    end

    // A write in flight always completes before an abort or slave error redirects to the stop write.
    always_comb begin
        state_next      = state;
        access_next     = access;
        abort_flag_next = abort_flag;
        case (state)
            IDLE: begin
                access_next = 1'b0;
                if (grant_valid)
                    state_next = (grant_period == 32'd0) ? FINISH : WR_CTRL_OFF;
            end
            WR_CTRL_OFF, WR_CMP, WR_CTRL_ON, WR_STOP: begin
                if (abort_i)
                    abort_flag_next = 1'b1;
                if (!access) begin
                    access_next = 1'b1;
                end else if (PREADY) begin
                    access_next = 1'b0;
                    if (PSLVERR)
                        abort_flag_next = 1'b1;
                    if (state == WR_STOP)
                        state_next = FINISH;
                    else if (abort_flag_next)
                        state_next = WR_STOP;
                    else if (state == WR_CTRL_OFF)
                        state_next = WR_CMP;
                    else if (state == WR_CMP)
                        state_next = WR_CTRL_ON;
                    else
                        state_next = WAIT_IRQ;
                end
            end
            WAIT_IRQ: begin
                if (abort_i) begin
                    abort_flag_next = 1'b1;
                    state_next      = WR_STOP;
                end else if (timer_cmp_irq_i) begin
                    state_next = WR_STOP;
                end
            end
            FINISH: begin
                abort_flag_next = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ack is gated by HRESETn so that every output reads 0 while reset is held.
    always_comb begin
        ack_o     = '0;
        done_o    = '0;
        aborted_o = '0;
        PADDR     = '0;
        PWDATA    = '0;
        PWRITE    = is_write;
        PSEL      = is_write;
        PENABLE   = is_write && access;
        busy_o    = (state != IDLE);
        cur_ch_o  = (state != IDLE) ? ch : '0;
        case (state)
            IDLE: begin
                if (grant_valid && HRESETn)
                    ack_o[grant_idx] = 1'b1;
            end
            WR_CTRL_OFF: PADDR = ADDR_CTRL;
            WR_CMP: begin
                PADDR  = ADDR_CMP;
                PWDATA = period;
            end
            WR_CTRL_ON: begin
                PADDR  = ADDR_CTRL;
                PWDATA = CTRL_ON;
            end
            WR_STOP: PADDR = ADDR_CTRL;
            FINISH: begin
                if (abort_flag)
                    aborted_o[ch] = 1'b1;
                else
                    done_o[ch] = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares one `timer` peripheral between `NUM_CH` requesters. Each requester asks for a one-shot delay of `period` timer ticks. The block grants one requester at a time and programs the timer through its APB slave port, acting as the sole APB master. It then waits for the timer's compare interrupt, stops the timer, and pulses that channel's `done_o`. It sits between the requesting hardware blocks and the timer's APB port and compare irq.

## Interface
- `NUM_CH`, 4: number of requester channels (2..8).
- `APB_ADDR_WIDTH`, 12: APB address width, matches the timer.
- `PRESCALER`, 3'd0: value written to timer CTRL[5:3] on enable; 0 means count every cycle.
- `HCLK` in 1: clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `req_i` in NUM_CH: per-channel request level.
- `period_i` in NUM_CH*32: per-channel delay; channel k uses `[32k+31:32k]`.
- `ack_o` out NUM_CH: one-cycle pulse when the request is captured.
- `done_o` out NUM_CH: one-cycle pulse when the delay expires normally.
- `aborted_o` out NUM_CH: one-cycle pulse when the sequence ends by abort or slave error.
- `abort_i` in 1: cancels the sequence in progress.
- `busy_o` out 1: high in every state except IDLE.
- `cur_ch_o` out $clog2(NUM_CH): index of the channel being serviced; 0 when idle.
- `PADDR` out APB_ADDR_WIDTH, `PWDATA` out 32, `PWRITE` out 1, `PSEL` out 1, `PENABLE` out 1: APB master outputs to the timer.
- `PREADY` in 1, `PSLVERR` in 1, `PRDATA` in 32: APB responses; `PRDATA` is unused.
- `timer_cmp_irq_i` in 1: the timer's compare-match irq, `irq_o[1]`.

## Operation
- States: IDLE, WR_CTRL_OFF, WR_CMP, WR_CTRL_ON, WAIT_IRQ, WR_STOP, FINISH.
- Every WR_* state performs one APB write in two phases:
  - setup: PSEL=1, PENABLE=0, for one cycle;
  - access: PSEL=1, PENABLE=1, held until PREADY.
- PWRITE=1 in every WR_* state. The block issues no reads.
- Timer register addresses:
  - WR_CTRL_OFF writes CTRL (0x004) = 0.
  - WR_CMP writes CMP (0x008) = the latched period. This also clears the timer count.
  - WR_CTRL_ON writes CTRL = {26'b0, PRESCALER, 2'b0, 1'b1}.
  - WR_STOP writes CTRL = 0.
- IDLE:
  - Channel selection is round-robin from pointer `rr` (reset 0). The first asserted `req_i[k]` at or after `rr`, with wrap, wins.
  - In that same cycle the block pulses `ack_o[k]` and latches k and `period_i[k]`, then sets `rr = (k+1) mod NUM_CH`.
  - If the latched period is 0, go straight to FINISH with no APB traffic. Otherwise go to WR_CTRL_OFF.
- The sequence always begins by disabling the timer. This makes the block robust to timer state left over from a prior reset.
- WAIT_IRQ samples `timer_cmp_irq_i` every cycle; the irq is a single-cycle level. On irq, go to WR_STOP.
- FINISH lasts one cycle:
  - pulse `done_o[ch]`, or `aborted_o[ch]` if the abort flag is set;
  - clear the abort flag;
  - return to IDLE.
- Abort handling:
  - `abort_i`, or PSLVERR=1 on a completing access phase, sets the abort flag.
  - The APB write in flight always completes first.
  - Then the block jumps to WR_STOP. If the abort happens in WR_STOP itself, it proceeds to FINISH.
  - In WAIT_IRQ, abort moves to WR_STOP on the next cycle.
  - `abort_i` in IDLE has no effect.
- If irq and abort arrive in the same WAIT_IRQ cycle, abort wins and the channel gets `aborted_o`.
- `req_i` must not be re-captured for a channel until its FINISH is done. A requester that holds `req_i` high after `ack_o` is re-queued as a new request.

## Timing
- Reset values:
  - all outputs are 0;
  - state is IDLE, `rr` = 0, abort flag clear.
- Reset asserted mid-operation returns to IDLE immediately and drops PSEL/PENABLE asynchronously. No stop write is issued; the next sequence's WR_CTRL_OFF covers it.
- Latency with PREADY tied high, request captured in cycle 0:
  - the WR_CTRL_OFF, WR_CMP and WR_CTRL_ON writes occupy cycles 1–6;
  - the timer count is 0 in cycle 7;
  - the irq fires in cycle 7+P;
  - WR_STOP occupies 8+P..9+P;
  - `done_o` pulses in cycle 10+P;
  - the next capture is possible in cycle 11+P.
- With a period of 0, `done_o` pulses in cycle 1.
- PREADY low extends the access phase. PADDR, PWDATA and PWRITE hold stable from setup through completion.
- `ack_o`, `done_o` and `aborted_o` are each exactly one cycle wide and are mutually exclusive per channel per cycle.

## Test plan
- Single request: `req_i[0]=1`, period 5, PRESCALER 0, PREADY=1.
  - Writes must be seen in this order: CTRL=0, CMP=5, CTRL=0x1, CTRL=0.
  - `done_o[0]` pulses at cycle 15.
- Round-robin: all four requests held high from reset, period 3 each.
  - `ack_o` order must be 0,1,2,3,0.
  - `busy_o` must drop only between sequences.
- Abort: `abort_i` pulsed in cycle 9 of a period-100 sequence.
  - The block issues CTRL=0 next.
  - `aborted_o[ch]` pulses, `done_o` stays 0, and there is no further irq wait.
- PSLVERR=1 on the CMP write, with PREADY stalled 3 cycles on each access.
  - The write completes after the stall.
  - The block then issues the WR_STOP write and pulses `aborted_o`.
  - The stretched access phases keep PADDR/PWDATA stable.
- Period 0 on channel 2: `ack_o[2]` in cycle 0, `done_o[2]` in cycle 1, zero APB transactions.
- HRESETn asserted during WAIT_IRQ: all outputs go to 0 immediately.
  - After release, a new request starts from WR_CTRL_OFF with `rr`=0.
